// File: rtl/tx_framer.sv
// GMII transmit framer: turns a raw frame byte stream into 9-bit FIFO write words,
// padding short frames, appending the CRC-32 FCS, a terminator, and an idle gap.
module tx_framer #(
  parameter int MIN_LEN    = 60,
  parameter int IFG_CYCLES = 12
) (
  input  logic       sys_clk,
  input  logic       sys_rst_n,
  input  logic       in_valid,
  input  logic [7:0] in_data,
  input  logic       in_last,
  output logic       in_ready,
  input  logic       out_full,
  output logic       wr_en,
  output logic [8:0] wr_data
);

  typedef enum logic [2:0] {IDLE, DATA, PAD, FCS, TERM, GAP} state_t;

  localparam logic [11:0] MIN_L    = 12'(MIN_LEN);
  localparam logic [7:0]  IFG_LAST = 8'(IFG_CYCLES - 1);
  localparam bit          NO_GAP   = (IFG_CYCLES == 0);

  state_t      state, state_nx;
  logic [10:0] byte_cnt, byte_cnt_nx, byte_inc;
  logic [11:0] cnt_p1, cnt_after;
  logic [31:0] crc, crc_nx;
  logic [1:0]  fcs_cnt, fcs_cnt_nx;
  logic [7:0]  gap_cnt, gap_cnt_nx;
  logic        wr_en_nx;
  logic [8:0]  wr_data_nx;
  logic        accept;

  // Reflected CRC-32, one byte per call, LSB first.
  function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] d);
    logic [31:0] r;
    r = c ^ {24'h0, d};
    for (int i = 0; i < 8; i++)
      r = r[0] ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
    return r;
  endfunction

  assign in_ready = (state == IDLE || state == DATA) && !out_full && sys_rst_n;
  assign accept   = in_valid && in_ready;
  assign byte_inc = (byte_cnt == 11'h7FF) ? byte_cnt : byte_cnt + 11'd1;
  assign cnt_p1   = {1'b0, byte_cnt} + 12'd1;

  always_comb begin
    state_nx    = state;
    byte_cnt_nx = byte_cnt;
    crc_nx      = crc;
    fcs_cnt_nx  = fcs_cnt;
    gap_cnt_nx  = gap_cnt;
    wr_en_nx    = 1'b0;
    wr_data_nx  = wr_data;
    cnt_after   = (state == IDLE) ? 12'd1 : cnt_p1;
    case (state)
      IDLE, DATA: begin
        if (accept) begin
          wr_en_nx   = 1'b1;
          wr_data_nx = {1'b1, in_data};
          if (state == IDLE) begin
            byte_cnt_nx = 11'd1;
            crc_nx      = crc_byte(32'hFFFF_FFFF, in_data);
          end else begin
            byte_cnt_nx = byte_inc;
            crc_nx      = crc_byte(crc, in_data);
          end
          fcs_cnt_nx = 2'd0;
          if (in_last) state_nx = (cnt_after < MIN_L) ? PAD : FCS;
          else         state_nx = DATA;
        end
      end
      PAD: begin
        if (!out_full) begin
          wr_en_nx    = 1'b1;
          wr_data_nx  = 9'h100;
          byte_cnt_nx = byte_inc;
          crc_nx      = crc_byte(crc, 8'h00);
          if (cnt_p1 >= MIN_L) state_nx = FCS;
        end
      end
      FCS: begin
        if (!out_full) begin
          wr_en_nx   = 1'b1;
          wr_data_nx = {1'b1, ~crc[{fcs_cnt, 3'b000} +: 8]};
          fcs_cnt_nx = fcs_cnt + 2'd1;
          if (fcs_cnt == 2'd3) state_nx = TERM;
        end
      end
      TERM: begin
        if (!out_full) begin
          wr_en_nx   = 1'b1;
          wr_data_nx = 9'h000;
          gap_cnt_nx = 8'd0;
          state_nx   = NO_GAP ? IDLE : GAP;
        end
      end
      GAP: begin
        // Idle gap runs on regardless of FIFO back-pressure.
        gap_cnt_nx = gap_cnt + 8'd1;
        if (gap_cnt == IFG_LAST) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state    <= IDLE;
      byte_cnt <= 11'd0;
      crc      <= 32'hFFFF_FFFF;
      fcs_cnt  <= 2'd0;
      gap_cnt  <= 8'd0;
      wr_en    <= 1'b0;
      wr_data  <= 9'h000;
    end else begin
      state    <= state_nx;
      byte_cnt <= byte_cnt_nx;
      crc      <= crc_nx;
      fcs_cnt  <= fcs_cnt_nx;
      gap_cnt  <= gap_cnt_nx;
      wr_en    <= wr_en_nx;
      wr_data  <= wr_data_nx;
    end
  end

endmodule

// File: doc/tx_framer.md
# tx_framer

Upstream stage of the GMII transmit path, running in the transmit FIFO's write-clock domain. It accepts a raw Ethernet frame as a byte stream (destination MAC through payload) and produces the 9-bit write stream that fills the transmit FIFO. In that stream, bit 8 = 1 marks a frame byte and a word with bit 8 = 0 marks end-of-frame. The block pads short frames, appends the CRC-32 FCS, writes the terminator word and enforces a minimum idle gap before the next frame.

## Interface
- MIN_LEN, 60: minimum frame length in bytes before FCS; the block pads with 0x00 up to this length. A value of 0 disables padding.
- IFG_CYCLES, 12: idle cycles after the terminator before the next frame is accepted; range 0..255.
- sys_clk  in  1  clock; the same clock as the transmit FIFO write side.
- sys_rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  in_data is valid.
- in_data  in  8  frame byte.
- in_last  in  1  marks the final byte of the frame; qualified by in_valid.
- in_ready  out  1  the block accepts a byte this cycle when in_valid && in_ready.
- out_full  in  1  almost-full from the transmit FIFO; guarantees at least 2 free entries while low.
- wr_en  out  1  write strobe to the transmit FIFO.
- wr_data  out  9  {frame_flag, byte}; goes to the FIFO write-data input.

## Operation
- States: IDLE, DATA, PAD, FCS, TERM, GAP.
- in_ready = (state==IDLE || state==DATA) && !out_full && sys_rst_n.
- Outputs are registered. Any word produced in cycle N appears as wr_en=1 with its wr_data in cycle N+1. wr_en is 0 in every other cycle.
- IDLE: on accept, emit {1,in_data}, set byte_cnt=1 and seed the CRC.
  - If in_last is also set, go to PAD or FCS (as in DATA); otherwise go to DATA.
- DATA: each accept emits {1,in_data} and increments byte_cnt. On an accept with in_last:
  - go to PAD if byte_cnt+1 < MIN_LEN;
  - otherwise go to FCS.
- PAD: emit {1,8'h00} and increment byte_cnt each non-stalled cycle. Go to FCS after the word that makes byte_cnt == MIN_LEN.
- FCS: emit 4 words {1,~crc[7:0]}, {1,~crc[15:8]}, {1,~crc[23:16]}, {1,~crc[31:24]}; then go to TERM.
- TERM: emit one word 9'h000, then go to GAP with gap_cnt=0.
- GAP: emit nothing; increment gap_cnt each cycle. Go to IDLE when gap_cnt == IFG_CYCLES-1. With IFG_CYCLES=0, go from TERM straight to IDLE.
- CRC rules:
  - reflected CRC-32, polynomial 0xEDB88320, 8 bits per cycle, LSB first;
  - initial value 0xFFFFFFFF, loaded at the start of each frame;
  - updated over every data byte and pad byte, never over FCS bytes.
- byte_cnt is 11 bits and saturates at 2047; no truncation of long frames.
- Stall rules:
  - In PAD, FCS and TERM, the block produces a word only when out_full=0.
  - While out_full=1, the state, counters and CRC hold and wr_en is 0 the next cycle.
  - GAP counting does not stall.
- Source contract: bytes of a frame arrive on consecutive in_ready cycles. An in_valid gap inside DATA is legal for this block (it holds, wr_en=0), but it can drain the FIFO and truncate the frame downstream. It is a source error, not detected here.

## Timing
- Reset, asynchronous assert: state=IDLE, wr_en=0, wr_data=9'h000, counters=0, crc=0xFFFFFFFF, in_ready=0. This takes effect immediately, without a clock edge.
- Reset mid-frame: the partial frame is abandoned with no terminator. The FIFO is reset by the same system reset.
- Reset release: in_ready may go high on the first clock edge after deassertion.
- Latency: byte accepted at edge N appears as wr_data at edge N+1.
- Output word count for a frame of L bytes, with no stalls: max(L,MIN_LEN)+5 (data, pad, 4 FCS bytes, terminator).
- Words are contiguous (one per cycle) from the first byte to the terminator, provided the source is contiguous and out_full=0.
- Cycle counts, first accept to next possible accept, no stalls:
  - at least max(L,MIN_LEN)+5+IFG_CYCLES cycles;
  - DATA→PAD/FCS transition costs no bubble;
  - FCS→TERM→GAP costs 5 cycles.
- Simultaneous in_last and out_full=1: no accept (in_ready=0); in_last is taken on the later accept.

## Test plan
- MIN_LEN=0, IFG_CYCLES=0; frame "123456789" (0x31..0x39) -> wr_data sequence 0x131..0x139, 0x126, 0x139, 0x1F4, 0x1CB, 0x000; 14 writes on 14 consecutive cycles.
- Default parameters; 14-byte frame -> 14 data words, 46 words 0x100, 4 FCS words matching a reference CRC over the 60 bytes, then 0x000; 65 writes total.
- 64-byte frame, out_full pulsed high for 3 cycles during DATA, PAD-free -> no pad words, no lost or duplicated words, in_ready=0 during the pulse. Repeat with the pulse during FCS: FCS bytes unchanged, only delayed.
- Back-to-back frames with in_valid held high, IFG_CYCLES=12 -> in_ready low exactly 12 cycles after the terminator write cycle; the second frame's CRC is independent of the first.
- 1-byte frame with in_last on the first accept, MIN_LEN=60 -> 1 data word, 59 pad words, 4 FCS words, terminator.
- Assert sys_rst_n low mid-PAD -> wr_en=0 and in_ready=0 immediately (before the next clock edge). After release, a fresh 60-byte frame is emitted correctly from IDLE.
